// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node write-data path.
package axi_node_pkg;

  // States of the W-channel router: normal routing, sinking an errored burst,
  // and signalling completion of the sink back to the AW decoder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SINK = 2'd1,
    DONE = 2'd2
  } wdata_state_e;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_dest_fifo.sv
// Generic synchronous FIFO used to queue one-hot W destinations.
// Head data is presented combinationally (show-ahead); push while full and
// pop while empty are ignored.
module axi_dest_fifo
  import axi_node_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  assign full_s   = (count_r == FULL_CNT);
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign push_s   = push & ~full_s;
  assign pop_s    = pop & ~empty_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage: clear on reset, write the tail entry on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_wdata_dest_router.sv
// W-channel router: queues destinations from the AW decoder, steers W beats
// to the head destination until WLAST, and sinks the W burst of an unmapped AW.
module axi_wdata_dest_router
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_DEST_i,
  input  logic [N_INIT_PORT-1:0]  DEST_i,
  output logic                    grant_FIFO_DEST_o,
  input  logic                    handle_error_i,
  output logic                    wdata_error_completed_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [USER_WIDTH-1:0]   wuser_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic [USER_WIDTH-1:0]   wuser_o,
  output logic                    wlast_o,
  output logic [N_INIT_PORT-1:0]  wvalid_o,
  input  logic [N_INIT_PORT-1:0]  wready_i
);

  wdata_state_e           state_r;
  wdata_state_e           state_next_s;
  logic                   fifo_push_s;
  logic                   fifo_pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [N_INIT_PORT-1:0] head_dest_s;

  // A zero destination carries no port, so it is never queued.
  assign fifo_push_s       = push_DEST_i & ~fifo_full_s & (DEST_i != {N_INIT_PORT{1'b0}});
  assign grant_FIFO_DEST_o = ~fifo_full_s;

  // Payload is broadcast; only the per-port valid selects the receiver.
  assign wdata_o = wdata_i;
  assign wstrb_o = wstrb_i;
  assign wuser_o = wuser_i;
  assign wlast_o = wlast_i;

  axi_dest_fifo #(
    .WIDTH (N_INIT_PORT),
    .DEPTH (FIFO_DEPTH)
  ) u_dest_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (DEST_i),
    .pop       (fifo_pop_s),
    .pop_data  (head_dest_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // State register for the routing/sink FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and handshake steering; a queued destination always takes
  // precedence over an error request so earlier bursts finish first.
  always_comb begin
    state_next_s            = state_r;
    wvalid_o                = {N_INIT_PORT{1'b0}};
    wready_o                = 1'b0;
    wdata_error_completed_o = 1'b0;
    fifo_pop_s              = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          wvalid_o     = {N_INIT_PORT{wvalid_i}} & head_dest_s;
          wready_o     = |(wready_i & head_dest_s);
          fifo_pop_s   = wvalid_i & wready_o & wlast_i;
          state_next_s = IDLE;
        end else if (handle_error_i) begin
          state_next_s = SINK;
        end else begin
          state_next_s = IDLE;
        end
      end
      SINK: begin
        wready_o = 1'b1;
        if (wvalid_i && wlast_i) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SINK;
        end
      end
      DONE: begin
        wdata_error_completed_o = 1'b1;
        if (!handle_error_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_wdata_dest_router.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_axi_wdata_dest_router;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int UW = 6;
  localparam int FD = 4;

  logic            clk;
  logic            rst;
  logic            push_DEST_i;
  logic [N-1:0]    DEST_i;
  logic            grant_FIFO_DEST_o;
  logic            handle_error_i;
  logic            wdata_error_completed_o;
  logic [DW-1:0]   wdata_i;
  logic [DW/8-1:0] wstrb_i;
  logic [UW-1:0]   wuser_i;
  logic            wlast_i;
  logic            wvalid_i;
  logic            wready_o;
  logic [DW-1:0]   wdata_o;
  logic [DW/8-1:0] wstrb_o;
  logic [UW-1:0]   wuser_o;
  logic            wlast_o;
  logic [N-1:0]    wvalid_o;
  logic [N-1:0]    wready_i;

  axi_wdata_dest_router #(
    .N_INIT_PORT (N),
    .DATA_WIDTH  (DW),
    .USER_WIDTH  (UW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .push_DEST_i             (push_DEST_i),
    .DEST_i                  (DEST_i),
    .grant_FIFO_DEST_o       (grant_FIFO_DEST_o),
    .handle_error_i          (handle_error_i),
    .wdata_error_completed_o (wdata_error_completed_o),
    .wdata_i                 (wdata_i),
    .wstrb_i                 (wstrb_i),
    .wuser_i                 (wuser_i),
    .wlast_i                 (wlast_i),
    .wvalid_i                (wvalid_i),
    .wready_o                (wready_o),
    .wdata_o                 (wdata_o),
    .wstrb_o                 (wstrb_o),
    .wuser_o                 (wuser_o),
    .wlast_o                 (wlast_o),
    .wvalid_o                (wvalid_o),
    .wready_i                (wready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending destinations in order, plus what the W side is doing.
  localparam int M_ROUTE = 0;
  localparam int M_SINK  = 1;
  localparam int M_DONE  = 2;
  logic [N-1:0] q[$];
  int           mode = M_ROUTE;

  logic         exp_grant;
  logic [N-1:0] exp_wvalid;
  logic         exp_wready;
  logic         exp_done;
  bit           hs_last;
  bit           cmp_en = 1'b0;
  int           done_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    exp_grant  = (q.size() < FD);
    exp_wvalid = '0;
    exp_wready = 1'b0;
    exp_done   = 1'b0;
    if (mode == M_ROUTE && q.size() != 0) begin
      if (wvalid_i) exp_wvalid = q[0];
      exp_wready = ((wready_i & q[0]) != '0);
    end else if (mode == M_SINK) begin
      exp_wready = 1'b1;
    end else if (mode == M_DONE) begin
      exp_done = 1'b1;
    end
  endtask

  task automatic model_update();
    bit was_empty;
    bit do_push;
    if (rst) begin
      q.delete();
      mode = M_ROUTE;
    end else begin
      was_empty = (q.size() == 0);
      do_push   = push_DEST_i && exp_grant && (DEST_i != '0);
      if (mode == M_ROUTE) begin
        if (!was_empty) begin
          if (wvalid_i && exp_wready && wlast_i) void'(q.pop_front());
        end else if (handle_error_i) begin
          mode = M_SINK;
        end
      end else if (mode == M_SINK) begin
        if (wvalid_i && wlast_i) mode = M_DONE;
      end else begin
        if (!handle_error_i) mode = M_ROUTE;
      end
      if (do_push) q.push_back(DEST_i);
    end
  endtask

  // One clock cycle with the currently applied inputs: compare mid-cycle, then clock the model.
  task automatic cycle();
    #2;
    model_eval();
    if (cmp_en) begin
      check("grant", grant_FIFO_DEST_o, exp_grant);
      check("wvalid_o", wvalid_o, exp_wvalid);
      check("wready_o", wready_o, exp_wready);
      check("completed", wdata_error_completed_o, exp_done);
      check("wvalid_onehot", ($countones(wvalid_o) <= 1), 1'b1);
      check("payload", {wlast_o, wuser_o, wstrb_o, wdata_o}, {wlast_i, wuser_i, wstrb_i, wdata_i});
    end
    if (wdata_error_completed_o === 1'b1) done_seen++;
    hs_last = exp_wready && wvalid_i;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    push_DEST_i    = 1'b0;
    DEST_i         = '0;
    wvalid_i       = 1'b0;
    wlast_i        = 1'b0;
    wready_i       = '0;
    wdata_i        = $urandom;
    wstrb_i        = 4'($urandom);
    wuser_i        = 6'($urandom);
  endtask

  task automatic push(input logic [N-1:0] d);
    push_DEST_i = 1'b1;
    DEST_i      = d;
    cycle();
    push_DEST_i = 1'b0;
    DEST_i      = '0;
  endtask

  // Drive a burst of nbeats; toggle makes port 0 ready only every other cycle.
  task automatic run_burst(input int nbeats, input bit toggle);
    int beat = 0;
    push_DEST_i = 1'b0;
    for (int c = 0; c < 64 && beat < nbeats; c++) begin
      wvalid_i = 1'b1;
      wlast_i  = (beat == nbeats - 1);
      wdata_i  = $urandom;
      wstrb_i  = 4'($urandom);
      wuser_i  = 6'($urandom);
      wready_i = (toggle && (c % 2 == 0)) ? 8'hFE : 8'hFF;
      cycle();
      if (hs_last) beat++;
    end
    if (beat < nbeats) check("burst_timeout", beat, nbeats);
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    handle_error_i = 1'b0;
    idle_inputs();
    cycle();
    cmp_en = 1'b1;
    cycle();
    rst = 1'b0;

    // Reset state
    #2;
    check("rst_grant", grant_FIFO_DEST_o, 1'b1);
    check("rst_wvalid", wvalid_o, 8'h00);
    check("rst_wready", wready_o, 1'b0);
    check("rst_completed", wdata_error_completed_o, 1'b0);
    cycle();

    // Basic route to port 2
    push(8'h04);
    run_burst(4, 1'b0);
    wvalid_i = 1'b1;
    wready_i = 8'hFF;
    #2;
    check("basic_empty_wvalid", wvalid_o, 8'h00);
    check("basic_empty_wready", wready_o, 1'b0);
    cycle();
    idle_inputs();

    // Ordered bursts with backpressure on port 0
    push(8'h01);
    push(8'h80);
    run_burst(2, 1'b1);
    wvalid_i = 1'b1;
    wready_i = 8'hFF;
    #2;
    check("order_second_head", wvalid_o, 8'h80);
    cycle();
    run_burst(2, 1'b0);
    idle_inputs();
    cycle();

    // Full FIFO, then simultaneous push and pop
    push(8'h01);
    push(8'h02);
    push(8'h04);
    push(8'h08);
    #2;
    check("full_grant", grant_FIFO_DEST_o, 1'b0);
    cycle();
    run_burst(1, 1'b0);
    push_DEST_i = 1'b1;
    DEST_i      = 8'h10;
    wvalid_i    = 1'b1;
    wlast_i     = 1'b1;
    wready_i    = 8'hFF;
    cycle();
    idle_inputs();
    #2;
    check("pushpop_grant", grant_FIFO_DEST_o, 1'b1);
    cycle();
    push(8'h20);
    #2;
    check("refull_grant", grant_FIFO_DEST_o, 1'b0);
    cycle();
    for (int i = 0; i < FD; i++) run_burst(1, 1'b0);
    idle_inputs();
    cycle();

    // Error sink of a 3-beat burst
    handle_error_i = 1'b1;
    cycle();
    run_burst(3, 1'b0);
    handle_error_i = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("sink_completed_pulses", done_seen, 1);

    // Error deferred behind an outstanding burst to port 1
    push(8'h02);
    handle_error_i = 1'b1;
    run_burst(2, 1'b0);
    #2;
    check("defer_not_yet_sink", wready_o, 1'b0);
    cycle();
    #2;
    check("defer_sink", wready_o, 1'b1);
    cycle();
    run_burst(1, 1'b0);
    handle_error_i = 1'b0;
    cycle();
    cycle();

    // Reset in the middle of a burst
    push(8'h04);
    wvalid_i = 1'b1;
    wready_i = 8'hFF;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    push(8'h00);
    wvalid_i = 1'b1;
    #2;
    check("midrst_grant", grant_FIFO_DEST_o, 1'b1);
    check("midrst_wvalid", wvalid_o, 8'h00);
    check("midrst_wready", wready_o, 1'b0);
    cycle();
    idle_inputs();

    // Randomized traffic
    begin
      bit err_active = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        rst         = ($urandom_range(0, 299) == 0);
        push_DEST_i = ($urandom_range(0, 3) == 0);
        DEST_i      = ($urandom_range(0, 7) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        wvalid_i    = ($urandom_range(0, 2) != 0);
        wlast_i     = ($urandom_range(0, 2) == 0);
        wready_i    = 8'($urandom);
        wdata_i     = $urandom;
        wstrb_i     = 4'($urandom);
        wuser_i     = 6'($urandom);
        if (!err_active && $urandom_range(0, 15) == 0) err_active = 1'b1;
        handle_error_i = err_active;
        cycle();
        if (exp_done || rst) err_active = 1'b0;
      end
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
